// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter and boot sequencer: shares a single-port RAM between the CPU
// fetch port and the boot loader, with starvation guard and zero-fill for out-of-range reads.
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  input  logic                  l_boot_done,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned   CntW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_loader_q, rsp_loader_d;
  logic            rsp_oor_q, rsp_oor_d;

  logic [31:0]     acc_addr;
  logic            acc_oor;
  logic [31:0]     rsp_data;

  // Grants are combinational; everything is forced off while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == StBoot) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        if (starve_q == CntMax) f_gnt = 1'b1;
        else                    l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    acc_addr  = l_gnt ? l_addr : f_addr;
    acc_oor   = |acc_addr[31:ADDR_WIDTH];
    mem_en    = (f_gnt | l_gnt) & ~acc_oor;
    mem_we    = mem_en & l_gnt & l_we;
    mem_addr  = mem_en ? acc_addr[ADDR_WIDTH-1:0] : '0;
    mem_wdata = mem_en ? l_wdata : '0;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StBoot && l_boot_done) state_d = StRun;

    starve_d = '0;
    if (state_q == StRun && f_req && !f_gnt) begin
      starve_d = (starve_q == CntMax) ? CntMax : starve_q + CntW'(1);
    end

    rsp_valid_d  = f_gnt | (l_gnt & ~l_we);
    rsp_loader_d = l_gnt;
    rsp_oor_d    = acc_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      starve_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_loader_q <= 1'b0;
      rsp_oor_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_loader_q <= rsp_loader_d;
      rsp_oor_q    <= rsp_oor_d;
    end
  end

  // Out-of-range reads never touched the RAM, so their data is zero-filled here.
  always_comb begin
    rsp_data = rsp_oor_q ? '0 : mem_rdata;
    f_rvalid = rst_n & rsp_valid_q & ~rsp_loader_q;
    l_rvalid = rst_n & rsp_valid_q & rsp_loader_q;
    f_rdata  = f_rvalid ? rsp_data : '0;
    l_rdata  = l_rvalid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: behavioural RAM, per-cycle reference model, directed and random stimulus.
module tb_imem_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req, l_req, l_we, l_boot_done;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [31:0]   f_rdata, l_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  imem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_boot_done(l_boot_done), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, 1-cycle read latency, preloaded with 0xA50000nn.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who wins, what the RAM holds, what the one outstanding read returns.
  logic [31:0] shadow [DEPTH];
  bit          m_boot = 1'b1;
  int          m_starve = 0;
  bit          m_pv = 1'b0, m_pl = 1'b0;
  logic [31:0] m_pd = '0;

  always @(negedge clk) begin
    int          winner;  // 0 none, 1 fetch, 2 loader
    logic [31:0] a;
    bit          inr, e_en, e_we;
    if (!rst_n) begin
      m_boot = 1'b1; m_starve = 0; m_pv = 1'b0;
      chk("rst_ctrl", {26'd0, f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we}, 32'd0);
      chk("rst_f_rdata", f_rdata, 32'd0);
      chk("rst_l_rdata", l_rdata, 32'd0);
      chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end else begin
      if (m_boot)                winner = l_req ? 2 : 0;
      else if (f_req && l_req)   winner = (m_starve == LIMIT) ? 1 : 2;
      else                       winner = f_req ? 1 : (l_req ? 2 : 0);
      a    = (winner == 2) ? l_addr : f_addr;
      inr  = a < DEPTH;
      e_en = (winner != 0) && inr;
      e_we = e_en && winner == 2 && l_we;
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, winner == 1});
      chk("l_gnt", {31'd0, l_gnt}, {31'd0, winner == 2});
      chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      chk("mem_addr", {26'd0, mem_addr}, e_en ? a % DEPTH : 32'd0);
      chk("mem_wdata", mem_wdata, e_en ? l_wdata : 32'd0);
      chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, m_pv && !m_pl});
      chk("l_rvalid", {31'd0, l_rvalid}, {31'd0, m_pv && m_pl});
      chk("f_rdata", f_rdata, (m_pv && !m_pl) ? m_pd : 32'd0);
      chk("l_rdata", l_rdata, (m_pv && m_pl) ? m_pd : 32'd0);
      m_pv = (winner == 1) || (winner == 2 && !l_we);
      m_pl = (winner == 2);
      m_pd = inr ? shadow[a % DEPTH] : 32'd0;
      if (e_we) shadow[a % DEPTH] = l_wdata;
      if (!m_boot && f_req && winner != 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                                 m_starve = 0;
      if (m_boot && l_boot_done) m_boot = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 8)  return 32'($urandom_range(0, DEPTH - 1));
    if (r == 8) return 32'(DEPTH + $urandom_range(0, 15));
    return $urandom;
  endfunction

  logic [0:9] pat = 10'b0000100001;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    f_req = 0; l_req = 0; l_we = 0; l_boot_done = 0;
    f_addr = 0; l_addr = 0; l_wdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Boot load: loader writes while fetch is locked out.
    f_req = 1; f_addr = 3; l_req = 1; l_we = 1; l_addr = 3; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("boot_f_locked", {31'd0, f_gnt}, 32'd0);
    chk("boot_l_gnt", {31'd0, l_gnt}, 32'd1);
    chk("boot_mem_we", {31'd0, mem_we}, 32'd1);
    step(); l_req = 0; l_boot_done = 1;
    @(negedge clk);
    chk("boot_done_f_gnt", {31'd0, f_gnt}, 32'd0);
    step(); l_boot_done = 0;
    @(negedge clk);
    chk("run_f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("run_mem_addr", {26'd0, mem_addr}, 32'd3);
    step(); f_req = 0;
    @(negedge clk);
    chk("run_f_rvalid", {31'd0, f_rvalid}, 32'd1);
    chk("run_f_rdata", f_rdata, 32'hDEAD_BEEF);

    // Out-of-range read and dropped write.
    step(); f_req = 1; f_addr = 32'h40;
    @(negedge clk);
    chk("oor_f_gnt", {31'd0, f_gnt}, 32'd1);
    chk("oor_mem_en", {31'd0, mem_en}, 32'd0);
    step(); f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h100; l_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("oor_f_rvalid", {31'd0, f_rvalid}, 32'd1);
    chk("oor_f_rdata", f_rdata, 32'd0);
    chk("oor_mem_we", {31'd0, mem_we}, 32'd0);
    step(); l_we = 0; l_addr = 0;
    step(); l_req = 0;
    @(negedge clk);
    chk("oor_readback", l_rdata, 32'hA500_0000);

    // Starvation guard: L,L,L,L,F repeating.
    step(); f_req = 1; f_addr = 6; l_req = 1; l_we = 0; l_addr = 5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_f_gnt", {31'd0, f_gnt}, {31'd0, pat[i]});
      step();
    end
    f_req = 0; l_req = 0;

    // Back-to-back fetch reads of 0,1,2.
    for (int i = 0; i < 4; i++) begin
      f_req = (i < 3); f_addr = 32'(i);
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("b2b_f_rdata", f_rdata, 32'hA500_0000 + 32'(i - 1));
      end
      step();
    end

    // Reset between a grant and its response.
    f_req = 1; f_addr = 2;
    @(negedge clk);
    chk("mid_f_gnt", {31'd0, f_gnt}, 32'd1);
    step(); rst_n = 0; l_req = 1;
    @(negedge clk);
    chk("mid_rst_quiet", {28'd0, f_gnt, l_gnt, mem_en, f_rvalid}, 32'd0);
    step(); rst_n = 1; l_req = 0;
    @(negedge clk);
    chk("mid_boot_f_gnt", {31'd0, f_gnt}, 32'd0);
    chk("mid_no_rvalid", {31'd0, f_rvalid}, 32'd0);
    step();

    // Random traffic, occasional resets and boot pulses.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      f_req       = ($urandom_range(0, 3) != 0);
      l_req       = ($urandom_range(0, 2) != 0);
      l_we        = $urandom_range(0, 1) == 1;
      f_addr      = rand_addr();
      l_addr      = rand_addr();
      l_wdata     = $urandom;
      l_boot_done = ($urandom_range(0, 15) == 0);
      step();
    end
    rst_n = 1; f_req = 0; l_req = 0; l_boot_done = 0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and boot sequencer for the CPU's single-port instruction memory. It shares the memory between the CPU fetch port and the boot-loader port (UART program loader / debug), holds the CPU out of memory until loading completes, and applies the zero-outside-range read rule for addresses beyond the memory depth. It sits between the fetch stage, the loader, and a synchronous instruction RAM with 1-cycle read latency.

## Interface
- ADDR_WIDTH, 6, word-address width of the memory (depth 2^ADDR_WIDTH words)
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch read request
- f_addr  in  32  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  32  loader word address
- l_wdata  in  32  loader write data
- l_boot_done  in  1  single-cycle pulse: program load complete
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  32  loader read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: BOOT (after reset), RUN. BOOT→RUN on l_boot_done=1 (takes effect next cycle). l_boot_done ignored in RUN. Only reset returns to BOOT.
- BOOT: f_gnt=0 always; l_gnt=l_req.
- RUN arbitration, same cycle (combinational from requests and registered state):
  - Only one requester: it is granted.
  - Both: loader wins, unless starve_cnt==STARVE_LIMIT, then fetch wins.
- starve_cnt (width clog2(STARVE_LIMIT+1)): in RUN, +1 each cycle f_req=1 and f_gnt=0, saturating at STARVE_LIMIT; cleared to 0 when f_gnt=1 or f_req=0. Held at 0 in BOOT.
- Granted access: in-range iff addr[31:ADDR_WIDTH]==0. In-range → mem_en=1, mem_we=(loader & l_we), mem_addr=addr[ADDR_WIDTH-1:0], mem_wdata=l_wdata. Out-of-range → mem_en=0; write silently dropped; read still completes with data 0.
- mem_en=0 → mem_we=0, mem_addr=0, mem_wdata=0.
- Response routing: register owner, is_read, and oor on each grant. Next cycle, the owner's rvalid=1 for reads only; rdata = oor ? 0 : mem_rdata. Non-owner rdata=0; rdata=0 whenever rvalid=0. Writes produce no rvalid.
- Back-to-back grants allowed every cycle; responses are strictly in grant order, one per cycle.

## Timing
- Reset (rst_n low, asynchronous): state=BOOT, starve_cnt=0, response registers cleared. While rst_n=0, f_gnt, l_gnt, mem_en, mem_we forced 0; f_rvalid=l_rvalid=0; rdata=0; mem_addr=mem_wdata=0.
- Grant latency 0 cycles (same cycle as req); read data latency 1 cycle after grant.
- Reset asserted between a grant and its response: the response is discarded (rvalid stays 0 after release).
- l_boot_done with l_req in the same BOOT cycle: the loader access is served; fetch is eligible from the next cycle.
- l_boot_done with f_req in that cycle: f_gnt=0 that cycle.
- Requesters must hold req/addr/data until gnt; arbiter keeps no request queue.

## Test plan
- Reset: assert rst_n=0 mid-simulation with f_req=l_req=1 → all grants, rvalids, mem_en read 0 immediately; after release, state BOOT (f_gnt=0 with f_req=1).
- Boot load: in BOOT, loader writes 0xDEADBEEF to addr 3 while f_req=1 → f_gnt=0 throughout. Pulse l_boot_done; fetch reads addr 3 → f_gnt same cycle, f_rvalid=1 with 0xDEADBEEF next cycle.
- Out-of-range: in RUN, fetch reads 0x40 (ADDR_WIDTH=6) → f_gnt=1, mem_en=0, next cycle f_rvalid=1, f_rdata=0. Loader write to 0x100 → mem_we never 1; readback of addr 0 unchanged.
- Starvation with STARVE_LIMIT=4: both requesting continuously in RUN → grant pattern L,L,L,L,F repeating; responses route to the correct port in grant order.
- Reset mid-read: grant a fetch read, drop rst_n in the following cycle before the edge → no f_rvalid after release; state BOOT.
- Back-to-back: alternating fetch reads of addrs 0,1,2 with idle loader → f_rvalid on 3 consecutive cycles with the matching words.
